// File: rtl/cpu_core_pkg.sv
// cpu_core_pkg
// Shared definitions for the single-cycle RV32I core: opcode and funct3
// encodings, the ALU operation set, writeback/next-pc selectors, the
// canonical NOP word and a small ALU-op decode helper.
// No ports (package).
package cpu_core_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Major opcodes (instr[6:0])
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;

  // Branch funct3
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // Load / store funct3
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // Integer ALU funct3 (shared by OP and OP_IMM)
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR,  ALU_AND
  } alu_op_t;

  typedef enum logic [2:0] {
    WB_ALU, WB_LOAD, WB_PC4, WB_IMM_U, WB_AUIPC
  } wb_sel_t;

  typedef enum logic [1:0] {
    PC_SEQ, PC_BRANCH, PC_JAL, PC_JALR
  } pc_sel_t;

  // alt selects SUB for funct3=000 and SRA for funct3=101.
  function automatic alu_op_t alu_decode(input logic [2:0] funct3, input logic alt);
    case (funct3)
      F3_ADD:  return alt ? ALU_SUB : ALU_ADD;
      F3_SLL:  return ALU_SLL;
      F3_SLT:  return ALU_SLT;
      F3_SLTU: return ALU_SLTU;
      F3_XOR:  return ALU_XOR;
      F3_SR:   return alt ? ALU_SRA : ALU_SRL;
      F3_OR:   return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/cpu_core_regfile.sv
// cpu_core_regfile
// 32 x XLEN integer register file, two combinational read ports and one
// write port. x0 always reads zero and ignores writes. Asynchronous
// active-high reset clears every register.
// Ports:
//   clk, rst            clock, async active-high reset
//   rs1_addr, rs2_addr  read port addresses
//   rs1_data, rs2_data  read port data (combinational)
//   we, rd_addr, rd_data write port, captured on rising clk
module cpu_core_regfile
  import cpu_core_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [4:0]      rs1_addr,
  input  logic [4:0]      rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  input  logic            we,
  input  logic [4:0]      rd_addr,
  input  logic [XLEN-1:0] rd_data
);

  logic [XLEN-1:0] regs [32];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= '0;
      end
    end else if (we && (rd_addr != 5'd0)) begin
      regs[rd_addr] <= rd_data;
    end
  end

  assign rs1_data = (rs1_addr == 5'd0) ? '0 : regs[rs1_addr];
  assign rs2_data = (rs2_addr == 5'd0) ? '0 : regs[rs2_addr];

endmodule

// File: rtl/cpu_core.sv
// cpu_core
// Single-cycle RV32I integer core with private instruction and data
// memories. Instruction memory is filled through a debug write port that
// works regardless of reset; after reset release the core fetches from 0
// and retires one instruction per clock.
// Ports:
//   clk        core clock, all state updates on rising edge
//   rst        asynchronous active-high reset (pc and registers only)
//   dbg_wr_en  debug instruction-memory write strobe
//   dbg_addr   byte address of the debug write (bits [1:0] ignored)
//   dbg_instr  instruction word to write
// Optional: define CPU_CORE_TRACE_EN to print a line per retired
// instruction (simulation only).
module cpu_core
  import cpu_core_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int IMEM_DEPTH = 256,
  parameter int DMEM_DEPTH = 256
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            dbg_wr_en,
  input  logic [XLEN-1:0] dbg_addr,
  input  logic [XLEN-1:0] dbg_instr
);

  localparam int IMEM_AW = $clog2(IMEM_DEPTH);
  localparam int DMEM_AW = $clog2(DMEM_DEPTH);

  // Power-up contents: NOPs in imem, zeros in dmem. Reset never clears them.
  logic [XLEN-1:0] imem [IMEM_DEPTH] = '{default: NOP_INSTR};
  logic [XLEN-1:0] dmem [DMEM_DEPTH] = '{default: '0};

  logic [XLEN-1:0]    pc, pc_plus4, pc_next;
  logic [XLEN-1:0]    instr;
  logic [6:0]         opcode, funct7;
  logic [4:0]         rd, rs1, rs2;
  logic [2:0]         funct3;
  logic [XLEN-1:0]    imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [XLEN-1:0]    rs1_data, rs2_data;
  logic               rf_we;
  logic [XLEN-1:0]    rd_wdata;
  alu_op_t            alu_op;
  logic [XLEN-1:0]    alu_b, alu_result;
  wb_sel_t            wb_sel;
  pc_sel_t            pc_sel;
  logic               branch_taken;
  logic               store_en;
  logic [3:0]         store_be;
  logic [XLEN-1:0]    store_data;
  logic [XLEN-1:0]    mem_addr, mem_rdata, load_data;
  logic [DMEM_AW-1:0] dmem_idx;
  logic               load_ok;
  logic [7:0]         ld_byte;
  logic [15:0]        ld_half;
  logic               unused_bits;

  assign instr  = imem[pc[IMEM_AW+1:2]];
  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign funct7 = instr[31:25];

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  cpu_core_regfile #(.XLEN(XLEN)) u_regfile (
    .clk      (clk),
    .rst      (rst),
    .rs1_addr (rs1),
    .rs2_addr (rs2),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .we       (rf_we),
    .rd_addr  (rd),
    .rd_data  (rd_wdata)
  );

  // Decode. Anything not recognised (including FENCE/SYSTEM and reserved
  // funct3/funct7 combinations) leaves every write disabled and falls
  // through to pc+4, i.e. behaves as a NOP.
  always_comb begin
    rf_we    = 1'b0;
    wb_sel   = WB_ALU;
    pc_sel   = PC_SEQ;
    alu_op   = ALU_ADD;
    alu_b    = rs2_data;
    store_en = 1'b0;
    case (opcode)
      LUI: begin
        rf_we  = 1'b1;
        wb_sel = WB_IMM_U;
      end
      AUIPC: begin
        rf_we  = 1'b1;
        wb_sel = WB_AUIPC;
      end
      JAL: begin
        rf_we  = 1'b1;
        wb_sel = WB_PC4;
        pc_sel = PC_JAL;
      end
      JALR: begin
        if (funct3 == 3'b000) begin
          rf_we  = 1'b1;
          wb_sel = WB_PC4;
          pc_sel = PC_JALR;
        end
      end
      BRANCH: pc_sel = PC_BRANCH;
      LOAD: begin
        rf_we  = load_ok;
        wb_sel = WB_LOAD;
      end
      STORE: store_en = (funct3 == F3_SB) || (funct3 == F3_SH) || (funct3 == F3_SW);
      OP_IMM: begin
        alu_b  = imm_i;
        alu_op = alu_decode(funct3, (funct3 == F3_SR) && funct7[5]);
        // For immediate shifts the upper immediate bits are funct7.
        if (funct3 == F3_SLL)
          rf_we = (funct7 == F7_BASE);
        else if (funct3 == F3_SR)
          rf_we = (funct7 == F7_BASE) || (funct7 == F7_ALT);
        else
          rf_we = 1'b1;
      end
      OP: begin
        alu_op = alu_decode(funct3, funct7[5]);
        rf_we  = (funct7 == F7_BASE) ||
                 ((funct7 == F7_ALT) && ((funct3 == F3_ADD) || (funct3 == F3_SR)));
      end
      default: ;
    endcase
  end

  // ALU; shifts use only the low five bits of the second operand.
  always_comb begin
    case (alu_op)
      ALU_ADD:  alu_result = rs1_data + alu_b;
      ALU_SUB:  alu_result = rs1_data - alu_b;
      ALU_SLL:  alu_result = rs1_data << alu_b[4:0];
      ALU_SLT:  alu_result = {{(XLEN-1){1'b0}}, $signed(rs1_data) < $signed(alu_b)};
      ALU_SLTU: alu_result = {{(XLEN-1){1'b0}}, rs1_data < alu_b};
      ALU_XOR:  alu_result = rs1_data ^ alu_b;
      ALU_SRL:  alu_result = rs1_data >> alu_b[4:0];
      ALU_SRA:  alu_result = $signed(rs1_data) >>> alu_b[4:0];
      ALU_OR:   alu_result = rs1_data | alu_b;
      default:  alu_result = rs1_data & alu_b;
    endcase
  end

  always_comb begin
    case (funct3)
      F3_BEQ:  branch_taken = (rs1_data == rs2_data);
      F3_BNE:  branch_taken = (rs1_data != rs2_data);
      F3_BLT:  branch_taken = ($signed(rs1_data) < $signed(rs2_data));
      F3_BGE:  branch_taken = ($signed(rs1_data) >= $signed(rs2_data));
      F3_BLTU: branch_taken = (rs1_data < rs2_data);
      F3_BGEU: branch_taken = (rs1_data >= rs2_data);
      default: branch_taken = 1'b0;
    endcase
  end

  // Data memory is word-organised; byte/half selection comes from the low
  // address bits, which are simply truncated for misaligned accesses.
  assign mem_addr  = rs1_data + ((opcode == STORE) ? imm_s : imm_i);
  assign dmem_idx  = mem_addr[DMEM_AW+1:2];
  assign mem_rdata = dmem[dmem_idx];
  assign ld_byte   = mem_rdata[{mem_addr[1:0], 3'b000} +: 8];
  assign ld_half   = mem_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];

  always_comb begin
    load_ok   = 1'b1;
    load_data = '0;
    case (funct3)
      F3_LB:   load_data = {{24{ld_byte[7]}}, ld_byte};
      F3_LH:   load_data = {{16{ld_half[15]}}, ld_half};
      F3_LW:   load_data = mem_rdata;
      F3_LBU:  load_data = {24'b0, ld_byte};
      F3_LHU:  load_data = {16'b0, ld_half};
      default: load_ok = 1'b0;
    endcase
  end

  // Stores replicate the source across lanes and enable only the lanes hit.
  always_comb begin
    case (funct3)
      F3_SB: begin
        store_be   = 4'b0001 << mem_addr[1:0];
        store_data = {4{rs2_data[7:0]}};
      end
      F3_SH: begin
        store_be   = mem_addr[1] ? 4'b1100 : 4'b0011;
        store_data = {2{rs2_data[15:0]}};
      end
      default: begin
        store_be   = 4'b1111;
        store_data = rs2_data;
      end
    endcase
  end

  assign pc_plus4 = pc + XLEN'(4);

  always_comb begin
    case (wb_sel)
      WB_LOAD:  rd_wdata = load_data;
      WB_PC4:   rd_wdata = pc_plus4;
      WB_IMM_U: rd_wdata = imm_u;
      WB_AUIPC: rd_wdata = pc + imm_u;
      default:  rd_wdata = alu_result;
    endcase
  end

  always_comb begin
    case (pc_sel)
      PC_BRANCH: pc_next = branch_taken ? (pc + imm_b) : pc_plus4;
      PC_JAL:    pc_next = pc + imm_j;
      PC_JALR:   pc_next = (rs1_data + imm_i) & ~XLEN'(1);
      default:   pc_next = pc_plus4;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      pc <= '0;
    else
      pc <= pc_next;
  end

  // Debug loads are independent of reset so a program can be written while
  // the core is held. A write to the word currently fetched lands at the
  // edge, so the old word is what executes this cycle.
  always_ff @(posedge clk) begin
    if (dbg_wr_en)
      imem[dbg_addr[IMEM_AW+1:2]] <= dbg_instr;
  end

  // Memory is not reset, so stores are suppressed while rst is held.
  always_ff @(posedge clk) begin
    if (!rst && store_en) begin
      for (int b = 0; b < 4; b++) begin
        if (store_be[b])
          dmem[dmem_idx][8*b +: 8] <= store_data[8*b +: 8];
      end
    end
  end

  assign unused_bits = ^{dbg_addr[XLEN-1:IMEM_AW+2], dbg_addr[1:0], mem_addr[XLEN-1:DMEM_AW+2]};

`ifdef CPU_CORE_TRACE_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (rf_we && (rd != 5'd0))
        $display("[TRACE] pc=%08h instr=%08h x%0d=%08h", pc, instr, rd, rd_wdata);
      else
        $display("[TRACE] pc=%08h instr=%08h", pc, instr);
    end
  end
`endif

endmodule

// File: tb/tb_cpu_core.sv
// tb_cpu_core
// Directed self-checking bench for cpu_core. Programs are written through
// the debug port while the core is held in reset, then run for a fixed
// number of cycles; architectural state is observed hierarchically.
module tb_cpu_core;

  localparam logic [6:0] T_OP_IMM = 7'b0010011;
  localparam logic [6:0] T_OP     = 7'b0110011;
  localparam logic [6:0] T_LOAD   = 7'b0000011;
  localparam logic [6:0] T_LUI    = 7'b0110111;
  localparam logic [6:0] T_AUIPC  = 7'b0010111;
  localparam logic [6:0] T_JALR   = 7'b1100111;
  localparam logic [31:0] T_NOP   = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        dbg_wr_en;
  logic [31:0] dbg_addr;
  logic [31:0] dbg_instr;

  int total = 0;
  int bad   = 0;

  cpu_core dut (
    .clk       (clk),
    .rst       (rst),
    .dbg_wr_en (dbg_wr_en),
    .dbg_addr  (dbg_addr),
    .dbg_instr (dbg_instr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2_i,
                                        input logic [4:0] rs1_i, input logic [2:0] f3,
                                        input logic [4:0] rd_i, input logic [6:0] op);
    return {f7, rs2_i, rs1_i, f3, rd_i, op};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1_i,
                                        input logic [2:0] f3, input logic [4:0] rd_i,
                                        input logic [6:0] op);
    return {imm, rs1_i, f3, rd_i, op};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2_i,
                                        input logic [4:0] rs1_i, input logic [2:0] f3);
    return {imm[11:5], rs2_i, rs1_i, f3, imm[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2_i,
                                        input logic [4:0] rs1_i, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2_i, rs1_i, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd_i,
                                        input logic [6:0] op);
    return {imm, rd_i, op};
  endfunction

  function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd_i);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd_i, 7'b1101111};
  endfunction

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [31:0] addr, input logic [31:0] word);
    dbg_wr_en = 1'b1;
    dbg_addr  = addr;
    dbg_instr = word;
    tick();
    dbg_wr_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    total++;
    if (dut.pc !== 32'd0) begin
      bad++;
      $display("[TB] FAIL reset_pc: got %08h want %08h", dut.pc, 32'd0);
    end
    for (int i = 1; i < 32; i++) begin
      total++;
      if (dut.u_regfile.regs[i] !== 32'd0) begin
        bad++;
        $display("[TB] FAIL reset_x%0d: got %08h want %08h", i, dut.u_regfile.regs[i], 32'd0);
      end
    end
    total++;
    if (dut.imem[200] !== T_NOP) begin
      bad++;
      $display("[TB] FAIL imem_init: got %08h want %08h", dut.imem[200], T_NOP);
    end
    total++;
    if (dut.dmem[200] !== 32'd0) begin
      bad++;
      $display("[TB] FAIL dmem_init: got %08h want %08h", dut.dmem[200], 32'd0);
    end
  endtask

  task automatic test_bge_program();
    rst = 1'b1;
    tick();
    load_word(32'd0,  T_NOP);
    load_word(32'd4,  32'h00C0_0093);
    load_word(32'd8,  32'h0020_0113);
    load_word(32'd12, 32'h0000_DC63);
    total++;
    if (dut.pc !== 32'd0) begin
      bad++;
      $display("[TB] FAIL hold_pc: got %08h want %08h", dut.pc, 32'd0);
    end
    rst = 1'b0;
    tick();
    tick();
    total++;
    if (dut.u_regfile.regs[1] !== 32'd12) begin
      bad++;
      $display("[TB] FAIL bge_x1: got %08h want %08h", dut.u_regfile.regs[1], 32'd12);
    end
    tick();
    total++;
    if (dut.u_regfile.regs[2] !== 32'd2) begin
      bad++;
      $display("[TB] FAIL bge_x2: got %08h want %08h", dut.u_regfile.regs[2], 32'd2);
    end
    tick();
    total++;
    if (dut.pc !== 32'd36) begin
      bad++;
      $display("[TB] FAIL bge_pc: got %08h want %08h", dut.pc, 32'd36);
    end
  endtask

  task automatic test_alu();
    logic [31:0] exp_reg [14];
    rst = 1'b1;
    tick();
    load_word(32'd0,  enc_i(12'd12, 5'd0, 3'b000, 5'd1, T_OP_IMM));
    load_word(32'd4,  enc_i(12'd2, 5'd0, 3'b000, 5'd2, T_OP_IMM));
    load_word(32'd8,  enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd3, T_OP));
    load_word(32'd12, enc_r(7'h20, 5'd2, 5'd1, 3'b000, 5'd4, T_OP));
    load_word(32'd16, enc_r(7'h00, 5'd1, 5'd2, 3'b010, 5'd5, T_OP));
    load_word(32'd20, enc_u(20'h80000, 5'd6, T_LUI));
    load_word(32'd24, enc_i(12'h404, 5'd6, 3'b101, 5'd7, T_OP_IMM));
    load_word(32'd28, enc_i(12'hFFF, 5'd1, 3'b010, 5'd8, T_OP_IMM));
    load_word(32'd32, enc_i(12'hFFF, 5'd1, 3'b011, 5'd9, T_OP_IMM));
    load_word(32'd36, enc_i(12'h004, 5'd6, 3'b101, 5'd10, T_OP_IMM));
    load_word(32'd40, enc_r(7'h00, 5'd1, 5'd2, 3'b001, 5'd11, T_OP));
    load_word(32'd44, enc_i(12'h0FF, 5'd1, 3'b100, 5'd12, T_OP_IMM));
    load_word(32'd48, enc_u(20'h00001, 5'd13, T_AUIPC));
    exp_reg[0]  = 32'd0;
    exp_reg[1]  = 32'd12;
    exp_reg[2]  = 32'd2;
    exp_reg[3]  = 32'd14;
    exp_reg[4]  = 32'd10;
    exp_reg[5]  = 32'd1;
    exp_reg[6]  = 32'h8000_0000;
    exp_reg[7]  = 32'hF800_0000;
    exp_reg[8]  = 32'd0;
    exp_reg[9]  = 32'd1;
    exp_reg[10] = 32'h0800_0000;
    exp_reg[11] = 32'h0000_2000;
    exp_reg[12] = 32'h0000_00F3;
    exp_reg[13] = 32'h0000_1030;
    rst = 1'b0;
    repeat (13) tick();
    for (int i = 1; i < 14; i++) begin
      total++;
      if (dut.u_regfile.regs[i] !== exp_reg[i]) begin
        bad++;
        $display("[TB] FAIL alu_x%0d: got %08h want %08h", i, dut.u_regfile.regs[i], exp_reg[i]);
      end
    end
    total++;
    if (dut.pc !== 32'd52) begin
      bad++;
      $display("[TB] FAIL alu_pc: got %08h want %08h", dut.pc, 32'd52);
    end
  endtask

  task automatic test_load_store();
    logic [31:0] exp_reg [10];
    rst = 1'b1;
    tick();
    load_word(32'd0,  enc_u(20'h12345, 5'd1, T_LUI));
    load_word(32'd4,  enc_i(12'h6FF, 5'd1, 3'b000, 5'd1, T_OP_IMM));
    load_word(32'd8,  enc_s(12'd16, 5'd1, 5'd0, 3'b010));
    load_word(32'd12, enc_i(12'd16, 5'd0, 3'b000, 5'd2, T_LOAD));
    load_word(32'd16, enc_i(12'd16, 5'd0, 3'b100, 5'd3, T_LOAD));
    load_word(32'd20, enc_i(12'd16, 5'd0, 3'b010, 5'd4, T_LOAD));
    load_word(32'd24, enc_i(12'd18, 5'd0, 3'b001, 5'd5, T_LOAD));
    load_word(32'd28, enc_s(12'd21, 5'd1, 5'd0, 3'b000));
    load_word(32'd32, enc_i(12'd20, 5'd0, 3'b010, 5'd6, T_LOAD));
    load_word(32'd36, enc_i(12'd21, 5'd0, 3'b001, 5'd7, T_LOAD));
    load_word(32'd40, enc_i(12'd22, 5'd0, 3'b101, 5'd8, T_LOAD));
    load_word(32'd44, enc_s(12'd26, 5'd1, 5'd0, 3'b001));
    load_word(32'd48, enc_i(12'd24, 5'd0, 3'b010, 5'd9, T_LOAD));
    exp_reg[0] = 32'd0;
    exp_reg[1] = 32'h1234_56FF;
    exp_reg[2] = 32'hFFFF_FFFF;
    exp_reg[3] = 32'h0000_00FF;
    exp_reg[4] = 32'h1234_56FF;
    exp_reg[5] = 32'h0000_1234;
    exp_reg[6] = 32'h0000_FF00;
    exp_reg[7] = 32'hFFFF_FF00;
    exp_reg[8] = 32'h0000_0000;
    exp_reg[9] = 32'h56FF_0000;
    rst = 1'b0;
    repeat (13) tick();
    for (int i = 1; i < 10; i++) begin
      total++;
      if (dut.u_regfile.regs[i] !== exp_reg[i]) begin
        bad++;
        $display("[TB] FAIL mem_x%0d: got %08h want %08h", i, dut.u_regfile.regs[i], exp_reg[i]);
      end
    end
    total++;
    if (dut.dmem[4] !== 32'h1234_56FF) begin
      bad++;
      $display("[TB] FAIL mem_word4: got %08h want %08h", dut.dmem[4], 32'h1234_56FF);
    end
  endtask

  task automatic test_branches();
    rst = 1'b1;
    tick();
    load_word(32'd0,  enc_i(12'hFFB, 5'd0, 3'b000, 5'd1, T_OP_IMM));
    load_word(32'd4,  enc_i(12'd3, 5'd0, 3'b000, 5'd2, T_OP_IMM));
    load_word(32'd8,  enc_b(13'd100, 5'd2, 5'd1, 3'b110));
    load_word(32'd12, enc_b(13'd8, 5'd2, 5'd1, 3'b100));
    load_word(32'd16, T_NOP);
    load_word(32'd20, enc_b(13'd8, 5'd2, 5'd1, 3'b000));
    load_word(32'd24, enc_b(13'h1FE8, 5'd2, 5'd1, 3'b111));
    rst = 1'b0;
    repeat (3) tick();
    total++;
    if (dut.pc !== 32'd12) begin
      bad++;
      $display("[TB] FAIL bltu_not_taken: got %08h want %08h", dut.pc, 32'd12);
    end
    tick();
    total++;
    if (dut.pc !== 32'd20) begin
      bad++;
      $display("[TB] FAIL blt_taken: got %08h want %08h", dut.pc, 32'd20);
    end
    tick();
    total++;
    if (dut.pc !== 32'd24) begin
      bad++;
      $display("[TB] FAIL beq_not_taken: got %08h want %08h", dut.pc, 32'd24);
    end
    tick();
    total++;
    if (dut.pc !== 32'd0) begin
      bad++;
      $display("[TB] FAIL bgeu_back: got %08h want %08h", dut.pc, 32'd0);
    end
  endtask

  task automatic test_jump_and_nop();
    rst = 1'b1;
    tick();
    load_word(32'd0,  32'h0000_0000);
    load_word(32'd4,  T_NOP);
    load_word(32'd8,  T_NOP);
    load_word(32'd12, T_NOP);
    load_word(32'd16, enc_j(21'd8, 5'd5));
    load_word(32'd20, enc_i(12'd5, 5'd0, 3'b000, 5'd0, T_OP_IMM));
    load_word(32'd24, enc_i(12'd1, 5'd5, 3'b000, 5'd0, T_JALR));
    rst = 1'b0;
    tick();
    total++;
    if (dut.pc !== 32'd4) begin
      bad++;
      $display("[TB] FAIL zero_op_pc: got %08h want %08h", dut.pc, 32'd4);
    end
    repeat (3) tick();
    tick();
    total++;
    if (dut.u_regfile.regs[5] !== 32'd20) begin
      bad++;
      $display("[TB] FAIL jal_link: got %08h want %08h", dut.u_regfile.regs[5], 32'd20);
    end
    total++;
    if (dut.pc !== 32'd24) begin
      bad++;
      $display("[TB] FAIL jal_pc: got %08h want %08h", dut.pc, 32'd24);
    end
    tick();
    total++;
    if (dut.pc !== 32'd20) begin
      bad++;
      $display("[TB] FAIL jalr_pc: got %08h want %08h", dut.pc, 32'd20);
    end
    tick();
    total++;
    if (dut.u_regfile.regs[0] !== 32'd0) begin
      bad++;
      $display("[TB] FAIL x0_write: got %08h want %08h", dut.u_regfile.regs[0], 32'd0);
    end
    total++;
    if (dut.pc !== 32'd24) begin
      bad++;
      $display("[TB] FAIL x0_pc: got %08h want %08h", dut.pc, 32'd24);
    end
  endtask

  task automatic test_midrun_reset();
    logic [31:0] new_word;
    new_word = enc_i(12'd9, 5'd0, 3'b000, 5'd1, T_OP_IMM);
    rst = 1'b1;
    tick();
    load_word(32'd0,  enc_i(12'd1, 5'd0, 3'b000, 5'd1, T_OP_IMM));
    load_word(32'd4,  enc_i(12'd2, 5'd0, 3'b000, 5'd2, T_OP_IMM));
    load_word(32'd8,  enc_i(12'd3, 5'd0, 3'b000, 5'd3, T_OP_IMM));
    load_word(32'd12, enc_j(21'h1FFFF4, 5'd0));
    rst = 1'b0;
    repeat (3) tick();
    total++;
    if (dut.u_regfile.regs[3] !== 32'd3) begin
      bad++;
      $display("[TB] FAIL pre_reset_x3: got %08h want %08h", dut.u_regfile.regs[3], 32'd3);
    end
    // Assert reset between edges: state must clear without a clock.
    rst = 1'b1;
    #1;
    total++;
    if (dut.pc !== 32'd0) begin
      bad++;
      $display("[TB] FAIL async_pc: got %08h want %08h", dut.pc, 32'd0);
    end
    for (int i = 1; i < 4; i++) begin
      total++;
      if (dut.u_regfile.regs[i] !== 32'd0) begin
        bad++;
        $display("[TB] FAIL async_x%0d: got %08h want %08h", i, dut.u_regfile.regs[i], 32'd0);
      end
    end
    tick();
    // Release and overwrite the word being fetched in the same cycle.
    rst       = 1'b0;
    dbg_wr_en = 1'b1;
    dbg_addr  = 32'd0;
    dbg_instr = new_word;
    tick();
    dbg_wr_en = 1'b0;
    total++;
    if (dut.u_regfile.regs[1] !== 32'd1) begin
      bad++;
      $display("[TB] FAIL collide_old_word: got %08h want %08h", dut.u_regfile.regs[1], 32'd1);
    end
    total++;
    if (dut.imem[0] !== new_word) begin
      bad++;
      $display("[TB] FAIL collide_imem: got %08h want %08h", dut.imem[0], new_word);
    end
    tick();
    total++;
    if (dut.u_regfile.regs[2] !== 32'd2) begin
      bad++;
      $display("[TB] FAIL rerun_x2: got %08h want %08h", dut.u_regfile.regs[2], 32'd2);
    end
    tick();
    tick();
    total++;
    if (dut.pc !== 32'd0) begin
      bad++;
      $display("[TB] FAIL loop_pc: got %08h want %08h", dut.pc, 32'd0);
    end
    tick();
    total++;
    if (dut.u_regfile.regs[1] !== 32'd9) begin
      bad++;
      $display("[TB] FAIL new_word_x1: got %08h want %08h", dut.u_regfile.regs[1], 32'd9);
    end
  endtask

  initial begin
    rst       = 1'b1;
    dbg_wr_en = 1'b0;
    dbg_addr  = 32'd0;
    dbg_instr = 32'd0;
    $display("[TB] starting cpu_core directed tests");
    test_reset();
    test_bge_program();
    test_alu();
    test_load_store();
    test_branches();
    test_jump_and_nop();
    test_midrun_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
